// File: rtl/phaser_coef_lfo.sv
// phaser_coef_lfo: triangle LFO producing the Q1.15 allpass feedback
// coefficient for the phaser.
//
// A phase accumulator advances on each sample_tick. A three-stage pipeline
// folds the phase into a triangle, scales it by depth, offsets it by base
// and saturates it to 0..32767.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   sample_tick  one-cycle strobe per audio sample
//   rate_inc     phase increment per tick (unsigned)
//   depth        modulation depth, 0..32767
//   base         coefficient offset, 0..32767
//   hold         freeze phase; ticks still produce a coefficient
//   phase_reset  synchronous phase clear; wins over hold and increment
//   coef         registered signed coefficient, always 0..32767
//   coef_valid   one-cycle pulse when coef updates
//   phase        current accumulator value
module phaser_coef_lfo #(
  parameter int unsigned PHASE_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] rate_inc,
  input  logic [14:0]        depth,
  input  logic [14:0]        base,
  input  logic               hold,
  input  logic               phase_reset,
  output logic [15:0]        coef,
  output logic               coef_valid,
  output logic [PHASE_W-1:0] phase
);

  localparam int unsigned TRI_W  = 16;
  localparam int unsigned PARM_W = 15;
  localparam int unsigned PROD_W = PARM_W + TRI_W;
  localparam logic [15:0] COEF_MAX = 16'h7FFF;

  // Stage 0 capture registers
  logic              v1;
  logic [PARM_W-1:0] depth_r;
  logic [PARM_W-1:0] base_r;

  // Stage 1 registers; depth/base travel with the triangle so back-to-back
  // ticks each use their own capture
  logic              v2;
  logic [TRI_W-1:0]  tri_r;
  logic [PARM_W-1:0] depth_r2;
  logic [PARM_W-1:0] base_r2;

  // Triangle fold and stage-2 arithmetic
  logic [TRI_W-1:0]  fold_c;
  logic [TRI_W-1:0]  tri_c;
  logic [PARM_W-1:0] prod_hi_c;
  logic [15:0]       sum_c;
  logic [15:0]       sat_c;

  always_comb begin
    fold_c    = phase[PHASE_W-2 -: TRI_W];
    tri_c     = phase[PHASE_W-1] ? ~fold_c : fold_c;
    prod_hi_c = PARM_W'((PROD_W'(depth_r2) * PROD_W'(tri_r)) >> TRI_W);
    sum_c     = 16'(base_r2) + 16'(prod_hi_c);
    sat_c     = (sum_c > COEF_MAX) ? COEF_MAX : sum_c;
  end

  // Phase accumulator; phase_reset acts with or without a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (phase_reset) begin
      phase <= '0;
    end else if (sample_tick && !hold) begin
      phase <= phase + rate_inc;
    end
  end

  // Stage 0: capture depth/base on the tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1      <= 1'b0;
      depth_r <= '0;
      base_r  <= '0;
    end else begin
      v1 <= sample_tick;
      if (sample_tick) begin
        depth_r <= depth;
        base_r  <= base;
      end
    end
  end

  // Stage 1: fold the updated phase into a triangle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2       <= 1'b0;
      tri_r    <= '0;
      depth_r2 <= '0;
      base_r2  <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        tri_r    <= tri_c;
        depth_r2 <= depth_r;
        base_r2  <= base_r;
      end
    end
  end

  // Stage 2: scale, offset, saturate; coef holds between updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef       <= '0;
      coef_valid <= 1'b0;
    end else begin
      coef_valid <= v2;
      if (v2) begin
        coef <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_phaser_coef_lfo.sv
module tb_phaser_coef_lfo;

  localparam int unsigned PHASE_W = 24;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_tick;
  logic [PHASE_W-1:0] rate_inc;
  logic [14:0]        depth;
  logic [14:0]        base;
  logic               hold;
  logic               phase_reset;
  logic [15:0]        coef;
  logic               coef_valid;
  logic [PHASE_W-1:0] phase;

  phaser_coef_lfo #(.PHASE_W(PHASE_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rate_inc    (rate_inc),
    .depth       (depth),
    .base        (base),
    .hold        (hold),
    .phase_reset (phase_reset),
    .coef        (coef),
    .coef_valid  (coef_valid),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned coef;
    int unsigned due;
  } exp_t;

  exp_t               q[$];
  int unsigned        vectors = 0;
  int unsigned        miscompares = 0;
  int unsigned        cyc = 0;
  int unsigned        last_coef = 0;
  logic [PHASE_W-1:0] m_phase = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: triangle over one phase period, scaled and offset, clipped
  function automatic int unsigned model_coef(input logic [PHASE_W-1:0] ph,
                                             input int unsigned d,
                                             input int unsigned b);
    longint unsigned half = 64'd1 << (PHASE_W - 1);
    longint unsigned pos  = longint'(ph) % half;
    longint unsigned lvl  = pos / (64'd1 << (PHASE_W - 17));
    longint unsigned s;
    if (longint'(ph) >= half) lvl = 65535 - lvl;
    s = longint'(b) + (longint'(d) * lvl) / 65536;
    return (s > 32767) ? 32767 : int'(s);
  endfunction

  // One clock of stimulus; model predicts phase and queues the coefficient
  task automatic step(input bit tick, input bit pr, input bit hl,
                      input logic [PHASE_W-1:0] rate,
                      input int unsigned d, input int unsigned b);
    exp_t e;
    @(negedge clk);
    sample_tick = tick;
    phase_reset = pr;
    hold        = hl;
    rate_inc    = rate;
    depth       = 15'(d);
    base        = 15'(b);
    if (pr) m_phase = '0;
    else if (tick && !hl) m_phase = m_phase + rate;
    if (tick) begin
      e.coef = model_coef(m_phase, d, b);
      e.due  = cyc + 3;
      q.push_back(e);
    end
    @(posedge clk);
    #2;
    check("phase", longint'(phase), longint'(m_phase));
    sample_tick = 1'b0;
    phase_reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, rate_inc, depth, base);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once
  task automatic reset_mid();
    @(negedge clk);
    #2;
    reset       = 1'b1;
    sample_tick = 1'b0;
    phase_reset = 1'b0;
    #1;
    check("rst_coef", longint'(coef), 0);
    check("rst_valid", longint'(coef_valid), 0);
    check("rst_phase", longint'(phase), 0);
    m_phase = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every valid pops one expectation; otherwise coef must hold
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      q.delete();
      last_coef = 0;
    end else if (coef_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("coef", longint'(coef), longint'(e.coef));
        check("latency", longint'(cyc), longint'(e.due));
        last_coef = e.coef;
      end
    end else begin
      check("coef_hold", longint'(coef), longint'(last_coef));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    sample_tick = 1'b0;
    phase_reset = 1'b0;
    hold        = 1'b0;
    rate_inc    = '0;
    depth       = '0;
    base        = '0;
    @(negedge clk);
    @(negedge clk);
    check("init_coef", longint'(coef), 0);
    check("init_valid", longint'(coef_valid), 0);
    check("init_phase", longint'(phase), 0);
    reset = 1'b0;
    idle(2);

    // Static output at phase 0
    step(1, 0, 0, '0, 32767, 12000);
    idle(3);

    // Full sweep through one period, fourth tick wraps
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 24'h400000, 32767, 0);
      idle(3);
    end

    // Saturation at the triangle peak
    step(0, 1, 0, '0, 0, 0);
    idle(2);
    step(1, 0, 0, 24'h800000, 32767, 30000);
    idle(3);

    // Hold: phase frozen, ticks still produce output
    for (int i = 0; i < 3; i++) step(1, 0, 1, 24'h123456, 20000, 5000);
    idle(3);

    // phase_reset beats hold and increment on a tick
    step(1, 1, 1, 24'h111111, 32767, 7777);
    idle(3);

    // phase_reset alone after moving the phase
    step(1, 0, 0, 24'h2ABCDE, 1000, 100);
    idle(3);
    step(0, 1, 0, 24'h2ABCDE, 1000, 100);
    idle(3);

    // Throughput: three back-to-back ticks
    for (int i = 0; i < 3; i++) step(1, 0, 0, 24'h400000, 32767, 0);
    idle(4);

    // Reset with a tick in flight: no valid may appear for it
    step(1, 0, 0, 24'h345678, 30000, 2000);
    reset_mid();
    idle(4);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 1) == 1),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0),
           PHASE_W'($urandom()),
           $urandom_range(0, 32767),
           $urandom_range(0, 32767));
    end
    idle(5);
    check("drain", longint'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
